// File: rtl/par2ser_pkg.sv
// Shared types and helpers for the par2ser parallel-to-serial converter.
package par2ser_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic int unsigned calc_ptr_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/par2ser.sv
// Parallel-to-serial converter: one DW*DEPTH block out as DEPTH DW-bit words,
// word 0 first, double-buffered (active + pending) for gap-free streaming.
module par2ser
  import par2ser_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 56,
  parameter int unsigned PTR_W = calc_ptr_w(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW*DEPTH-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_data,
  output logic [PTR_W-1:0]    out_idx,
  output logic                out_last,
  output logic                busy
);

  localparam int unsigned     BW       = $clog2(DW * DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  state_t                state;
  logic                  pend_vld;
  logic [PTR_W-1:0]      rd_ptr;
  logic [DW*DEPTH-1:0]   active_buf;
  logic [DW*DEPTH-1:0]   pend_buf;

  logic                  beat;
  logic                  last_beat;
  logic                  accept;
  logic [BW-1:0]         word_base;

  always_comb begin
    beat      = (state == SEND) & out_ready;
    last_beat = beat & (rd_ptr == LAST_PTR);
    accept    = in_valid & ~pend_vld;
    word_base = BW'(rd_ptr) * BW'(DW);
  end

  assign out_valid = (state == SEND);
  assign out_data  = out_valid ? active_buf[word_base +: DW] : '0;
  assign out_idx   = rd_ptr;
  assign out_last  = out_valid & (rd_ptr == LAST_PTR);
  assign busy      = (state == SEND) | pend_vld;
  assign in_ready  = ~pend_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pend_vld   <= 1'b0;
      rd_ptr     <= '0;
      active_buf <= '0;
      pend_buf   <= '0;
    end else begin
      if (beat) begin
        rd_ptr <= last_beat ? '0 : rd_ptr + PTR_W'(1);
      end

      unique case (state)
        IDLE: begin
          if (accept) begin
            active_buf <= in_data;
            state      <= SEND;
          end
        end
        SEND: begin
          // A block offered on the final beat bypasses pending when it is empty,
          // so the next word 0 follows the last word with no bubble.
          if (last_beat) begin
            if (pend_vld) begin
              active_buf <= pend_buf;
              pend_vld   <= 1'b0;
            end else if (accept) begin
              active_buf <= in_data;
            end else begin
              state <= IDLE;
            end
          end else if (accept) begin
            pend_buf <= in_data;
            pend_vld <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_par2ser.sv
// Directed self-checking bench for par2ser: ordering, latency, back-pressure,
// capacity, same-edge reload and asynchronous reset mid-block.
module tb_par2ser;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 56;
  localparam int unsigned PTR_W = 6;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [DW*DEPTH-1:0] in_data = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [DW-1:0]       out_data;
  logic [PTR_W-1:0]    out_idx;
  logic                out_last;
  logic                busy;

  par2ser #(.DW(DW), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 1;
  int beats = 0;
  int last_beat_cyc = 0;
  logic [DW-1:0] exp_q[$];
  int            exp_idx_q[$];
  int            last_cyc_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Scoreboard: sampled on the falling edge, a beat is valid&ready seen here.
  initial begin
    logic          stall;
    logic [DW-1:0] pd;
    logic [PTR_W-1:0] pi;
    logic [DW-1:0] ed;
    int            ei;
    stall = 1'b0;
    pd = '0;
    pi = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("hold_valid", 64'(out_valid), 64'd1);
          check("hold_data", 64'(out_data), 64'(pd));
          check("hold_idx", 64'(out_idx), 64'(pi));
        end
        if (!out_valid) begin
          check("idle_data", 64'(out_data), 64'd0);
          check("idle_last", 64'(out_last), 64'd0);
        end else if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_beat", 64'd1, 64'd0);
          end else begin
            ed = exp_q.pop_front();
            ei = exp_idx_q.pop_front();
            check("beat_data", 64'(out_data), 64'(ed));
            check("beat_idx", 64'(out_idx), 64'(ei));
            check("beat_last", 64'(out_last), 64'(ei == DEPTH - 1));
            beats++;
            last_beat_cyc = cyc;
            if (ei == DEPTH - 1) last_cyc_q.push_back(cyc);
          end
        end
        stall = out_valid && !out_ready;
        pd = out_data;
        pi = out_idx;
      end
    end
  end

  task automatic send_block(input logic [DW-1:0] base, input int budget, output int acc_cyc);
    bit acc;
    acc = 1'b0;
    acc_cyc = -1;
    for (int k = 0; k < DEPTH; k++) in_data[k*DW +: DW] = base + DW'(k);
    in_valid = 1'b1;
    for (int w = 0; w < budget && !acc; w++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        acc_cyc = cyc;
        for (int k = 0; k < DEPTH; k++) begin
          exp_q.push_back(base + DW'(k));
          exp_idx_q.push_back(k);
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    for (int k = 0; k < DEPTH; k++) in_data[k*DW +: DW] = $urandom;
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain(input int budget);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < budget) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
    check("drain_valid", 64'(out_valid), 64'd0);
    check("drain_busy", 64'(busy), 64'd0);
    check("drain_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    int t0, b0, n0, acc_a, acc_b, acc_c, acc_y, w;

    ready_mode = 1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_idx", 64'(out_idx), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single block, word 0 visible right after the accept edge.
    send_block(32'hA000_0000, 10, acc_a);
    check("t1_lat_valid", 64'(out_valid), 64'd1);
    check("t1_lat_idx", 64'(out_idx), 64'd0);
    check("t1_lat_data", 64'(out_data), 64'hA000_0000);
    drain(200);

    // Back-to-back blocks: 112 beats over 112 consecutive cycles.
    b0 = beats;
    send_block(32'hA000_0000, 10, acc_a);
    t0 = cyc;
    send_block(32'hB000_0000, 10, acc_b);
    check("t2_b_accept_cyc", 64'(acc_b), 64'(acc_a + 1));
    check("t2_in_ready_full", 64'(in_ready), 64'd0);
    check("t2_busy", 64'(busy), 64'd1);
    drain(300);
    check("t2_beats", 64'(beats - b0), 64'(2 * DEPTH));
    check("t2_span", 64'(last_beat_cyc - t0), 64'(2 * DEPTH - 1));

    // Third block held off until the active block's last beat frees pending.
    n0 = last_cyc_q.size();
    send_block(32'hA100_0000, 10, acc_a);
    send_block(32'hB100_0000, 10, acc_b);
    send_block(32'hC100_0000, 200, acc_c);
    check("t3_c_after_last", 64'(acc_c), 64'(last_cyc_q[n0] + 1));
    check("t3_in_ready_after", 64'(in_ready), 64'd0);
    check("t3_busy", 64'(busy), 64'd1);
    drain(400);

    // Random back-pressure: hold checks and exact sequence via scoreboard.
    ready_mode = 2;
    send_block(32'hD000_0000, 10, acc_a);
    drain(2000);
    ready_mode = 1;
    @(posedge clk);
    #1;

    // New block accepted on the same edge as the active block's last beat.
    send_block(32'h5000_0000, 10, acc_a);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!(out_valid && out_idx == PTR_W'(DEPTH - 2)) && w < 100);
    check("t5_reach_54", 64'(out_idx), 64'(DEPTH - 2));
    @(posedge clk);
    #1;
    send_block(32'h6000_0000, 2, acc_y);
    check("t5_same_edge", 64'(acc_y), 64'(last_cyc_q[$]));
    check("t5_valid", 64'(out_valid), 64'd1);
    check("t5_idx", 64'(out_idx), 64'd0);
    check("t5_data", 64'(out_data), 64'h6000_0000);
    check("t5_in_ready", 64'(in_ready), 64'd1);
    drain(200);

    // Asynchronous reset at word 20 with a block pending.
    send_block(32'h7000_0000, 10, acc_a);
    send_block(32'h8000_0000, 10, acc_b);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (out_idx != PTR_W'(20) && w < 100);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_data", 64'(out_data), 64'd0);
    check("t6_rst_idx", 64'(out_idx), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    exp_idx_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_post_valid", 64'(out_valid), 64'd0);
      check("t6_post_busy", 64'(busy), 64'd0);
      check("t6_post_in_ready", 64'(in_ready), 64'd1);
    end
    @(posedge clk);
    #1;
    send_block(32'h9000_0000, 10, acc_a);
    check("t6_fresh_idx", 64'(out_idx), 64'd0);
    check("t6_fresh_data", 64'(out_data), 64'h9000_0000);
    drain(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    check("watchdog", 64'd0, 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
